uart_fifo_cfg: RTL and testbench
================================

// Module: uart_fifo_cfg
// PURPOSE
//  Parametrised successor UART with TX/RX FIFOs: configurable data width, parity mode, stop bits and FIFO depth.
//  Adds per-FIFO fill levels, RX framing/parity/overrun error flags with an explicit clear, and 16x oversampled RX.
//  Sits between fabric logic (byte producer/consumer) and external UART pins; one instance per serial channel.
// PARAMETERS
//  pClkFreq      12_000_000  system clock in Hz
//  pBaudRate     9600        line rate; oversample divisor pDiv = pClkFreq/(pBaudRate*16), truncated, must be >=1
//  pDataBits     8           data bits per frame, 5..9
//  pParity       0           0=none, 1=odd, 2=even
//  pStopBits     1           1 or 2 stop bits (TX sends; RX checks only the first)
//  pTxFifoDepth  8           TX FIFO entries, power of 2, >=2
//  pRxFifoDepth  8           RX FIFO entries, power of 2, >=2
// PORTS
//  iClk      in   1                        system clock; single clock domain, all logic posedge
//  iRst      in   1                        synchronous active-high reset
//  iTxEn     in   1                        write iTxData to TX FIFO this cycle
//  iTxData   in   pDataBits                TX word
//  oTxFull   out  1                        TX FIFO full
//  oTxLevel  out  $clog2(pTxFifoDepth)+1   TX FIFO occupancy
//  iRxEn     in   1                        pop RX FIFO this cycle
//  oRxData   out  pDataBits                RX head word (first-word-fall-through, valid while !oRxEmpty)
//  oRxEmpty  out  1                        RX FIFO empty
//  oRxLevel  out  $clog2(pRxFifoDepth)+1   RX FIFO occupancy
//  iErrClr   in   1                        clear all sticky error flags
//  iRx       in   1                        external RX line (async)
//  oTx       out  1                        external TX line
//  oFrameErr out  1                        sticky: stop bit sampled low
//  oParErr   out  1                        sticky: parity mismatch
//  oOverrun  out  1                        sticky: RX word received while RX FIFO full (word dropped)
//  oRcvErr   out  1                        OR of the three sticky flags
// BEHAVIOUR
//  Reset: oTx=1, FIFOs empty, levels=0, oTxFull=0, oRxEmpty=1, oRxData=0, all error flags 0, both FSMs IDLE, tick counter 0.
//  Tick gen: counter 0..pDiv-1, one-cycle tick at pDiv-1; shared by TX and RX; free-running.
//  FIFO: write when en && !full; read when en && !empty; write on full dropped (level unchanged); read on empty ignored.
//   Simultaneous wr+rd: on full both occur (level unchanged); on empty only write occurs. Pointers wrap mod depth.
//   Level/flags update the cycle after the strobe; FWFT head visible on oRxData the cycle after first write.
//  TX FSM IDLE->START->DATA->[PARITY]->STOP->IDLE; each bit 16 ticks. In IDLE with TX FIFO non-empty: pop one word,
//   enter START on next tick boundary. LSB first. STOP lasts pStopBits*16 ticks, then fetch next word with no idle gap.
//  RX: iRx passes 2-FF synchroniser. IDLE: falling edge -> START; at 8th tick re-sample; if high return IDLE (glitch),
//   else DATA. Each subsequent bit sampled at its 16th tick after mid-start (centre). PARITY checked if pParity!=0.
//   STOP: low -> set oFrameErr, word discarded, wait for line high before IDLE. High -> push word (if FIFO full: set oOverrun,
//   drop). Parity error: set oParErr, word still pushed. Return to IDLE right after stop sample (half-bit early).
//  Error flags: set on event, cleared only by iErrClr or iRst; set and clear in same cycle -> set wins.
//  Reset mid-frame: both FSMs abort immediately; oTx driven 1 next cycle; partial RX word discarded.
// CONFIGURATION
//  UART_FIFO_CFG_LOOPBACK_EN defined: extra input iLoopback (1 bit); when 1, RX sampler takes internal TX serial
//   line instead of iRx and oTx is held 1. Undefined: port absent, RX always from iRx.
// STRUCTURE
//  Package uart_cfg_pkg: parity enum (NONE/ODD/EVEN), TX and RX FSM state encodings, OVERSAMPLE=16, MID_SAMPLE=8.
//  One reusable sub-module fifo_sync_lvl (width/depth params, FWFT, level output), instantiated twice.
//  TX/RX FSMs and tick generator live in this module.
// TESTING (pClkFreq=12_000_000, pBaudRate=750_000 -> pDiv=1, 16 clk/bit unless noted)
//  Write 0xA5, 8N1 -> oTx: start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 16 clk; oTxLevel 1->0 on pop.
//  Write 9 words to 8-deep TX FIFO in 9 back-to-back cycles -> oTxFull=1 after 8th, 9th dropped, level=8.
//  Loopback/drive iRx with 0x3C, pParity=2 (even) correct parity -> oRxData=0x3C, oRxEmpty=0, no errors.
//  Drive frame with wrong parity bit -> oParErr=1, oRcvErr=1, word still in FIFO; pulse iErrClr -> flags 0.
//  Drive stop bit low -> oFrameErr=1, oRxLevel unchanged; 9 frames with no reads -> oOverrun=1, oRxLevel=8.
//  2-clk low glitch on idle iRx -> no word, no error; iRst mid-TX-frame -> oTx=1 next cycle, levels 0.

Source files
------------

// File: rtl/uart_cfg_pkg.sv
// Shared types and constants for the configurable FIFO UART.
// Parity selector, TX/RX state encodings and oversampling constants.
package uart_cfg_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_e;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 8;

   // Parity bit to send (or expect) given the XOR of the data bits.
   function automatic logic parity_bit(input logic data_xor, input logic odd_mode);
      return odd_mode ? ~data_xor : data_xor;
   endfunction

endpackage

// File: rtl/fifo_sync_lvl.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// The head word is held in a register so it is stable and resets to zero;
// storage is a plain array without reset.
module fifo_sync_lvl #(
   parameter int pWidth = 8,
   parameter int pDepth = 8
) (
   input  logic                      clk_i,
   input  logic                      srst_i,
   input  logic                      wr_en_i,
   input  logic [pWidth-1:0]         wr_data_i,
   input  logic                      rd_en_i,
   output logic [pWidth-1:0]         rd_data_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [$clog2(pDepth):0]   level_o
);
   import uart_cfg_pkg::*;

   localparam int AW = $clog2(pDepth);
   localparam int LW = AW + 1;

   logic [pWidth-1:0] mem [pDepth];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [pWidth-1:0] head_q, head_d;
   logic              full, empty, wr_ok, rd_ok;

   assign full  = (level_q == LW'(pDepth));
   assign empty = (level_q == '0);
   // A write into a full FIFO is only accepted when a read frees a slot in the same cycle.
   assign wr_ok = wr_en_i && (!full || rd_en_i);
   assign rd_ok = rd_en_i && !empty;

   // Pointer, level and head-word next state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q + LW'(wr_ok) - LW'(rd_ok);
      head_d   = head_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         if (level_q > LW'(1))
            head_d = mem[rd_ptr_q + 1'b1];
         else if (wr_ok)
            head_d = wr_data_i;
      end else if (empty && wr_ok) begin
         head_d = wr_data_i;
      end
   end

   // Storage array write port.
   always_ff @(posedge clk_i) begin
      if (wr_ok) mem[wr_ptr_q] <= wr_data_i;
   end

   // Control and head registers.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
      end
   end

   assign rd_data_o = head_q;
   assign full_o    = full;
   assign empty_o   = empty;
   assign level_o   = level_q;

endmodule

// File: rtl/uart_fifo_cfg.sv
// Configurable UART with TX/RX FIFOs, sticky RX error flags and 16x oversampled RX.
// Optional feature macro: UART_FIFO_CFG_LOOPBACK_EN adds iLoopback, which routes the
// internal TX serial line into the RX sampler and holds oTx high.
module uart_fifo_cfg #(
   parameter int pClkFreq     = 12_000_000,
   parameter int pBaudRate    = 9600,
   parameter int pDataBits    = 8,
   parameter int pParity      = 0,
   parameter int pStopBits    = 1,
   parameter int pTxFifoDepth = 8,
   parameter int pRxFifoDepth = 8
) (
   input  logic                          iClk,
   input  logic                          iRst,
   input  logic                          iTxEn,
   input  logic [pDataBits-1:0]          iTxData,
   output logic                          oTxFull,
   output logic [$clog2(pTxFifoDepth):0] oTxLevel,
   input  logic                          iRxEn,
   output logic [pDataBits-1:0]          oRxData,
   output logic                          oRxEmpty,
   output logic [$clog2(pRxFifoDepth):0] oRxLevel,
   input  logic                          iErrClr,
`ifdef UART_FIFO_CFG_LOOPBACK_EN
   input  logic                          iLoopback,
`endif
   input  logic                          iRx,
   output logic                          oTx,
   output logic                          oFrameErr,
   output logic                          oParErr,
   output logic                          oOverrun,
   output logic                          oRcvErr
);
   import uart_cfg_pkg::*;

   localparam int   DIV       = pClkFreq / (pBaudRate * OVERSAMPLE);
   localparam int   DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic PARITY_EN = (pParity != int'(PAR_NONE));
   localparam logic ODD_MODE  = (pParity == int'(PAR_ODD));

   // ---------------- oversample tick ----------------
   logic [DIV_W-1:0] tick_cnt_q;
   logic             tick;

   assign tick = (tick_cnt_q == DIV_W'(DIV - 1));

   // Free-running divider producing one tick per 1/16 bit.
   always_ff @(posedge iClk) begin
      if (iRst || tick) tick_cnt_q <= '0;
      else              tick_cnt_q <= tick_cnt_q + 1'b1;
   end

   // ---------------- FIFOs ----------------
   logic                 tx_pop, tx_empty;
   logic [pDataBits-1:0] tx_head;
   logic                 rx_push, rx_full;
   logic [pDataBits-1:0] rx_shift_q, rx_shift_d;

   fifo_sync_lvl #(.pWidth(pDataBits), .pDepth(pTxFifoDepth)) u_tx_fifo (
      .clk_i     (iClk),
      .srst_i    (iRst),
      .wr_en_i   (iTxEn),
      .wr_data_i (iTxData),
      .rd_en_i   (tx_pop),
      .rd_data_o (tx_head),
      .full_o    (oTxFull),
      .empty_o   (tx_empty),
      .level_o   (oTxLevel)
   );

   fifo_sync_lvl #(.pWidth(pDataBits), .pDepth(pRxFifoDepth)) u_rx_fifo (
      .clk_i     (iClk),
      .srst_i    (iRst),
      .wr_en_i   (rx_push),
      .wr_data_i (rx_shift_q),
      .rd_en_i   (iRxEn),
      .rd_data_o (oRxData),
      .full_o    (rx_full),
      .empty_o   (oRxEmpty),
      .level_o   (oRxLevel)
   );

   // ---------------- TX ----------------
   tx_state_e            tx_state_q, tx_state_d;
   logic [3:0]           tx_tcnt_q, tx_tcnt_d;
   logic [3:0]           tx_bit_q, tx_bit_d;
   logic [pDataBits-1:0] tx_shift_q, tx_shift_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_line_q, tx_line_d;
   logic                 tx_bit_end;

   // The 4-bit tick counter wraps every 16 ticks, which marks each bit boundary.
   assign tx_bit_end = tick && (tx_tcnt_q == 4'(OVERSAMPLE - 1));

   // TX next state; the line value is derived from the next state so oTx is registered.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_tcnt_d  = tick ? tx_tcnt_q + 1'b1 : tx_tcnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_pop     = 1'b0;
      unique case (tx_state_q)
         TX_IDLE: begin
            if (!tx_empty && tick) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_head;
               tx_par_d   = parity_bit(^tx_head, ODD_MODE);
               tx_tcnt_d  = '0;
               tx_bit_d   = '0;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_bit_d   = '0;
               tx_state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_shift_d = tx_shift_q >> 1;
               if (tx_bit_q == 4'(pDataBits - 1)) begin
                  tx_bit_d   = '0;
                  tx_state_d = PARITY_EN ? TX_PARITY : TX_STOP;
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
               end
            end
         end
         TX_PARITY: begin
            if (tx_bit_end) begin
               tx_bit_d   = '0;
               tx_state_d = TX_STOP;
            end
         end
         TX_STOP: begin
            if (tx_bit_end) begin
               if (tx_bit_q == 4'(pStopBits - 1)) begin
                  // Chain straight into the next frame when more data is queued.
                  if (!tx_empty) begin
                     tx_pop     = 1'b1;
                     tx_shift_d = tx_head;
                     tx_par_d   = parity_bit(^tx_head, ODD_MODE);
                     tx_tcnt_d  = '0;
                     tx_bit_d   = '0;
                     tx_state_d = TX_START;
                  end else begin
                     tx_state_d = TX_IDLE;
                  end
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase

      unique case (tx_state_d)
         TX_START:  tx_line_d = 1'b0;
         TX_DATA:   tx_line_d = tx_shift_d[0];
         TX_PARITY: tx_line_d = tx_par_d;
         default:   tx_line_d = 1'b1;
      endcase
   end

   // TX state registers.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         tx_state_q <= TX_IDLE;
         tx_tcnt_q  <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_line_q  <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_tcnt_q  <= tx_tcnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         tx_line_q  <= tx_line_d;
      end
   end

   // ---------------- RX ----------------
   logic rx_src;
`ifdef UART_FIFO_CFG_LOOPBACK_EN
   assign rx_src = iLoopback ? tx_line_q : iRx;
   assign oTx    = iLoopback ? 1'b1 : tx_line_q;
`else
   assign rx_src = iRx;
   assign oTx    = tx_line_q;
`endif

   logic       rx_s1_q, rx_s2_q, rx_s3_q;
   rx_state_e  rx_state_q, rx_state_d;
   logic [3:0] rx_tcnt_q, rx_tcnt_d;
   logic [3:0] rx_bit_q, rx_bit_d;
   logic       rx_sample;
   logic       frame_set, par_set, overrun_set;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
         rx_s3_q <= 1'b1;
      end else begin
         rx_s1_q <= rx_src;
         rx_s2_q <= rx_s1_q;
         rx_s3_q <= rx_s2_q;
      end
   end

   // Sample points after the start-bit check fall 16 ticks apart, at bit centres.
   assign rx_sample = tick && (rx_tcnt_q == 4'(OVERSAMPLE - 1));

   // RX next state, word assembly and error event detection.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_tcnt_d  = tick ? rx_tcnt_q + 1'b1 : rx_tcnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_push    = 1'b0;
      frame_set  = 1'b0;
      par_set    = 1'b0;
      unique case (rx_state_q)
         RX_IDLE: begin
            rx_tcnt_d = '0;
            if (!rx_s2_q && rx_s3_q) rx_state_d = RX_START;
         end
         RX_START: begin
            if (tick && rx_tcnt_q == 4'(MID_SAMPLE - 1)) begin
               rx_tcnt_d = '0;
               rx_bit_d  = '0;
               // A line that is high again at mid-start was only a glitch.
               rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_sample) begin
               rx_shift_d = {rx_s2_q, rx_shift_q[pDataBits-1:1]};
               if (rx_bit_q == 4'(pDataBits - 1)) begin
                  rx_state_d = PARITY_EN ? RX_PARITY : RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 1'b1;
               end
            end
         end
         RX_PARITY: begin
            if (rx_sample) begin
               par_set    = (rx_s2_q != parity_bit(^rx_shift_q, ODD_MODE));
               rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_sample) begin
               if (!rx_s2_q) begin
                  frame_set  = 1'b1;
                  rx_state_d = RX_WAIT_HIGH;
               end else begin
                  rx_push    = 1'b1;
                  rx_state_d = RX_IDLE;
               end
            end
         end
         RX_WAIT_HIGH: begin
            if (rx_s2_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // A push that the FIFO cannot accept is an overrun; a same-cycle pop makes room.
   assign overrun_set = rx_push && rx_full && !iRxEn;

   // RX state registers.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         rx_state_q <= RX_IDLE;
         rx_tcnt_q  <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_tcnt_q  <= rx_tcnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // Sticky error flags; a new event in the clear cycle keeps the flag set.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         oFrameErr <= 1'b0;
         oParErr   <= 1'b0;
         oOverrun  <= 1'b0;
      end else begin
         oFrameErr <= frame_set   | (oFrameErr & ~iErrClr);
         oParErr   <= par_set     | (oParErr   & ~iErrClr);
         oOverrun  <= overrun_set | (oOverrun  & ~iErrClr);
      end
   end

   assign oRcvErr = oFrameErr | oParErr | oOverrun;

endmodule

// File: tb/tb_uart_fifo_cfg.sv
// Directed self-checking bench for uart_fifo_cfg, 8 data bits, even parity, 1 stop bit,
// 16 clocks per bit. Inputs driven and outputs sampled on the falling clock edge.
module tb_uart_fifo_cfg;

   logic       clk = 1'b0;
   logic       iRst, iTxEn, iRxEn, iErrClr, iRx;
   logic [7:0] iTxData;
   logic       oTxFull, oRxEmpty, oTx, oFrameErr, oParErr, oOverrun, oRcvErr;
   logic [3:0] oTxLevel, oRxLevel;
   logic [7:0] oRxData;

   int checks   = 0;
   int failures = 0;

   // 0xA5 with even parity: start, LSB-first data, parity, stop.
   logic       exp_bits [0:10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   // Words with an even number of ones, so their even-parity bit is 0.
   logic [7:0] ov_data  [0:8]  = '{8'h00, 8'h03, 8'h05, 8'h06, 8'h09, 8'h0A, 8'h0C, 8'h0F, 8'h11};

   always #5 clk = ~clk;

   uart_fifo_cfg #(
      .pClkFreq    (12_000_000),
      .pBaudRate   (750_000),
      .pDataBits   (8),
      .pParity     (2),
      .pStopBits   (1),
      .pTxFifoDepth(8),
      .pRxFifoDepth(8)
   ) dut (
      .iClk      (clk),
      .iRst      (iRst),
      .iTxEn     (iTxEn),
      .iTxData   (iTxData),
      .oTxFull   (oTxFull),
      .oTxLevel  (oTxLevel),
      .iRxEn     (iRxEn),
      .oRxData   (oRxData),
      .oRxEmpty  (oRxEmpty),
      .oRxLevel  (oRxLevel),
      .iErrClr   (iErrClr),
      .iRx       (iRx),
      .oTx       (oTx),
      .oFrameErr (oFrameErr),
      .oParErr   (oParErr),
      .oOverrun  (oOverrun),
      .oRcvErr   (oRcvErr)
   );

   // Drive one serial frame onto iRx, then a short idle gap.
   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      iRx = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         iRx = d[i];
         repeat (16) @(negedge clk);
      end
      iRx = p;
      repeat (16) @(negedge clk);
      iRx = s;
      repeat (16) @(negedge clk);
      iRx = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic pulse_reset();
      iRst = 1'b1;
      @(negedge clk);
      iRst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      iRst = 1'b1; iTxEn = 1'b0; iTxData = '0; iRxEn = 1'b0; iErrClr = 1'b0; iRx = 1'b1;
      repeat (3) @(negedge clk);
      iRst = 1'b0;
      @(negedge clk);
      checks++; if (oTx !== 1'b1)     begin failures++; $display("FAIL reset_tx got=%b exp=1", oTx); end
      checks++; if (oTxLevel !== 4'd0) begin failures++; $display("FAIL reset_txlvl got=%0d exp=0", oTxLevel); end
      checks++; if (oTxFull !== 1'b0) begin failures++; $display("FAIL reset_txfull got=%b exp=0", oTxFull); end
      checks++; if (oRxEmpty !== 1'b1) begin failures++; $display("FAIL reset_rxempty got=%b exp=1", oRxEmpty); end
      checks++; if (oRxLevel !== 4'd0) begin failures++; $display("FAIL reset_rxlvl got=%0d exp=0", oRxLevel); end
      checks++; if (oRxData !== 8'h00) begin failures++; $display("FAIL reset_rxdata got=%h exp=00", oRxData); end
      checks++; if ({oFrameErr, oParErr, oOverrun, oRcvErr} !== 4'b0000)
         begin failures++; $display("FAIL reset_errs got=%b exp=0000", {oFrameErr, oParErr, oOverrun, oRcvErr}); end
      $display("reset: checked idle state");
   endtask

   task automatic test_tx_frame();
      bit found = 0;
      iTxEn = 1'b1; iTxData = 8'hA5;
      @(negedge clk);
      iTxEn = 1'b0;
      checks++; if (oTxLevel !== 4'd1) begin failures++; $display("FAIL tx_level_push got=%0d exp=1", oTxLevel); end
      for (int i = 0; i < 40; i++) begin
         if (oTx === 1'b0) begin found = 1; break; end
         @(negedge clk);
      end
      checks++; if (!found) begin failures++; $display("FAIL tx_start_timeout got=no start exp=start bit"); end
      repeat (8) @(negedge clk);
      for (int b = 0; b < 11; b++) begin
         if (b != 0) repeat (16) @(negedge clk);
         checks++;
         if (oTx !== exp_bits[b]) begin
            failures++; $display("FAIL tx_bit%0d got=%b exp=%b", b, oTx, exp_bits[b]);
         end
      end
      checks++; if (oTxLevel !== 4'd0) begin failures++; $display("FAIL tx_level_pop got=%0d exp=0", oTxLevel); end
      repeat (16) @(negedge clk);
      $display("tx_frame: sent A5 8E1");
   endtask

   task automatic test_tx_full();
      iTxEn = 1'b1; iTxData = 8'h11;
      @(negedge clk);
      iTxEn = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (oTxLevel !== 4'd0) begin failures++; $display("FAIL txfull_first_pop got=%0d exp=0", oTxLevel); end
      for (int i = 0; i < 9; i++) begin
         iTxEn = 1'b1; iTxData = 8'(8'h20 + i);
         @(negedge clk);
         if (i == 7) begin
            checks++; if (oTxFull !== 1'b1) begin failures++; $display("FAIL txfull_after8 got=%b exp=1", oTxFull); end
         end
      end
      iTxEn = 1'b0;
      @(negedge clk);
      checks++; if (oTxLevel !== 4'd8) begin failures++; $display("FAIL txfull_level got=%0d exp=8", oTxLevel); end
      checks++; if (oTxFull !== 1'b1) begin failures++; $display("FAIL txfull_flag got=%b exp=1", oTxFull); end
      $display("tx_full: 9 writes into 8-deep FIFO");
   endtask

   task automatic test_reset_mid_tx();
      bit found = 0;
      for (int i = 0; i < 200; i++) begin
         if (oTx === 1'b0) begin found = 1; break; end
         @(negedge clk);
      end
      checks++; if (!found) begin failures++; $display("FAIL midrst_low_timeout got=no low exp=low bit"); end
      iRst = 1'b1;
      @(negedge clk);
      iRst = 1'b0;
      checks++; if (oTx !== 1'b1)      begin failures++; $display("FAIL midrst_tx got=%b exp=1", oTx); end
      checks++; if (oTxLevel !== 4'd0) begin failures++; $display("FAIL midrst_txlvl got=%0d exp=0", oTxLevel); end
      checks++; if (oTxFull !== 1'b0)  begin failures++; $display("FAIL midrst_txfull got=%b exp=0", oTxFull); end
      repeat (20) @(negedge clk);
      checks++; if (oTx !== 1'b1)      begin failures++; $display("FAIL midrst_tx_idle got=%b exp=1", oTx); end
      $display("reset_mid_tx: aborted frame");
   endtask

   task automatic test_rx_good();
      send_frame(8'h3C, 1'b0, 1'b1);
      checks++; if (oRxEmpty !== 1'b0) begin failures++; $display("FAIL rxgood_empty got=%b exp=0", oRxEmpty); end
      checks++; if (oRxData !== 8'h3C) begin failures++; $display("FAIL rxgood_data got=%h exp=3c", oRxData); end
      checks++; if (oRxLevel !== 4'd1) begin failures++; $display("FAIL rxgood_level got=%0d exp=1", oRxLevel); end
      checks++; if (oRcvErr !== 1'b0)  begin failures++; $display("FAIL rxgood_err got=%b exp=0", oRcvErr); end
      iRxEn = 1'b1;
      @(negedge clk);
      iRxEn = 1'b0;
      checks++; if (oRxEmpty !== 1'b1) begin failures++; $display("FAIL rxgood_pop_empty got=%b exp=1", oRxEmpty); end
      checks++; if (oRxLevel !== 4'd0) begin failures++; $display("FAIL rxgood_pop_level got=%0d exp=0", oRxLevel); end
      $display("rx_good: received 3C");
   endtask

   task automatic test_rx_parity();
      send_frame(8'h81, 1'b1, 1'b1);
      checks++; if (oParErr !== 1'b1)  begin failures++; $display("FAIL rxpar_flag got=%b exp=1", oParErr); end
      checks++; if (oRcvErr !== 1'b1)  begin failures++; $display("FAIL rxpar_rcverr got=%b exp=1", oRcvErr); end
      checks++; if (oRxData !== 8'h81) begin failures++; $display("FAIL rxpar_data got=%h exp=81", oRxData); end
      checks++; if (oRxLevel !== 4'd1) begin failures++; $display("FAIL rxpar_level got=%0d exp=1", oRxLevel); end
      iErrClr = 1'b1;
      @(negedge clk);
      iErrClr = 1'b0;
      checks++; if ({oParErr, oRcvErr} !== 2'b00) begin failures++; $display("FAIL rxpar_clear got=%b exp=00", {oParErr, oRcvErr}); end
      iRxEn = 1'b1;
      @(negedge clk);
      iRxEn = 1'b0;
      $display("rx_parity: bad parity flagged, word kept");
   endtask

   task automatic test_rx_frame();
      send_frame(8'h55, 1'b0, 1'b0);
      checks++; if (oFrameErr !== 1'b1) begin failures++; $display("FAIL rxframe_flag got=%b exp=1", oFrameErr); end
      checks++; if (oRcvErr !== 1'b1)   begin failures++; $display("FAIL rxframe_rcverr got=%b exp=1", oRcvErr); end
      checks++; if (oParErr !== 1'b0)   begin failures++; $display("FAIL rxframe_par got=%b exp=0", oParErr); end
      checks++; if (oRxLevel !== 4'd0)  begin failures++; $display("FAIL rxframe_level got=%0d exp=0", oRxLevel); end
      iErrClr = 1'b1;
      @(negedge clk);
      iErrClr = 1'b0;
      checks++; if (oFrameErr !== 1'b0) begin failures++; $display("FAIL rxframe_clear got=%b exp=0", oFrameErr); end
      $display("rx_frame: stop low discarded");
   endtask

   task automatic test_rx_overrun();
      for (int i = 0; i < 8; i++) send_frame(ov_data[i], 1'b0, 1'b1);
      checks++; if (oRxLevel !== 4'd8) begin failures++; $display("FAIL ovr_level8 got=%0d exp=8", oRxLevel); end
      checks++; if (oOverrun !== 1'b0) begin failures++; $display("FAIL ovr_early got=%b exp=0", oOverrun); end
      send_frame(ov_data[8], 1'b0, 1'b1);
      checks++; if (oOverrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", oOverrun); end
      checks++; if (oRxLevel !== 4'd8) begin failures++; $display("FAIL ovr_level got=%0d exp=8", oRxLevel); end
      checks++; if (oRxData !== ov_data[0]) begin failures++; $display("FAIL ovr_head got=%h exp=%h", oRxData, ov_data[0]); end
      iRxEn = 1'b1;
      @(negedge clk);
      iRxEn = 1'b0;
      checks++; if (oRxData !== ov_data[1]) begin failures++; $display("FAIL ovr_head2 got=%h exp=%h", oRxData, ov_data[1]); end
      checks++; if (oRxLevel !== 4'd7) begin failures++; $display("FAIL ovr_level7 got=%0d exp=7", oRxLevel); end
      iErrClr = 1'b1;
      @(negedge clk);
      iErrClr = 1'b0;
      checks++; if (oOverrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", oOverrun); end
      $display("rx_overrun: 9 frames into 8-deep FIFO");
   endtask

   task automatic test_rx_glitch();
      pulse_reset();
      iRx = 1'b0;
      repeat (2) @(negedge clk);
      iRx = 1'b1;
      repeat (40) @(negedge clk);
      checks++; if (oRxEmpty !== 1'b1) begin failures++; $display("FAIL glitch_empty got=%b exp=1", oRxEmpty); end
      checks++; if (oRxLevel !== 4'd0) begin failures++; $display("FAIL glitch_level got=%0d exp=0", oRxLevel); end
      checks++; if (oRcvErr !== 1'b0)  begin failures++; $display("FAIL glitch_err got=%b exp=0", oRcvErr); end
      $display("rx_glitch: 2-clk low ignored");
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_tx_frame();
      test_tx_full();
      test_reset_mid_tx();
      test_rx_good();
      test_rx_parity();
      test_rx_frame();
      test_rx_overrun();
      test_rx_glitch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
